// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory ready/timeout, BNE, trap state and retire counter.
// Optional addi support is compiled in when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_ctrl #(
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write_cond,
    output logic             pc_write_cond_n,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    // state   | meaning
    // FETCH   | read instruction, PC+4 on mem_ready
    // DECODE  | register read, branch target, dispatch on opcode
    // MEMADR  | effective address for lw/sw
    // MEMRD   | data read, wait for mem_ready
    // MEMWB   | load result to rt
    // MEMWR   | data write, wait for mem_ready
    // EXEC    | R-type ALU operation
    // RWB     | R-type result to rd
    // BRANCH  | compare and conditional PC write (beq/bne)
    // JUMP    | PC <- jump target
    // ADDI_EX | rs + imm (only with MIPS_CTRL_ADDI_EN)
    // ADDI_WB | addi result to rt (only with MIPS_CTRL_ADDI_EN)
    // TRAP    | PC <- exception vector, one-cycle trap pulse
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
`endif
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam bit               TMO_EN  = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         cause_q, cause_d;
    logic               is_bne_q, is_bne_d;
    logic               is_sw_q, is_sw_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               in_wait;
    logic               timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            cause_q    <= 2'b00;
            is_bne_q   <= 1'b0;
            is_sw_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
            is_bne_q   <= is_bne_d;
            is_sw_q    <= is_sw_d;
            retired_q  <= retired_d;
        end
    end

    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timed_out = TMO_EN && !mem_ready && (wait_cnt_q == TMO_MAX);

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        is_bne_d        = is_bne_q;
        is_sw_d         = is_sw_q;
        retire          = 1'b0;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        pc_write        = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_to_reg      = 1'b0;
        ir_write        = 1'b0;
        alu_src_a       = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        pc_source       = 2'b00;
        alu_op          = 2'b00;
        alu_src_b       = 2'b00;
        trap            = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    // Held in reset the FSM sits here; keep IR/PC untouched until released.
                    ir_write = rst_n;
                    pc_write = rst_n;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                is_bne_d  = (opcode == OP_BNE);
                is_sw_d   = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:        state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_source       = 2'b01;
                pc_write_cond   = !is_bne_q;
                pc_write_cond_n = is_bne_q;
                state_d         = S_FETCH;
                retire          = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
`endif
            S_TRAP: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                trap      = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Any state change clears the wait counter, so every wait state starts from zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_wait && !mem_ready && (wait_cnt_q != TMO_MAX)) begin
            wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign state      = state_q;

endmodule
